pulse_sequencer: RTL and testbench

Parametrised pulse-phase sequencer for the processor control path. It steps through `N_PHASE` machine phases. Each phase either auto-advances after one cycle or waits for a selected external reply, such as memory, the operator or the console. It adds halt-at-cycle-end, single-step and a reply timeout with a fault state. Per-phase one-hot strobes drive the register-transfer and memory/operate request logic of the instruction cycle.

---
 rtl/pulse_sequencer_pkg.sv | 22 ++
 rtl/pulse_sequencer_reply_capture.sv | 23 ++
 rtl/pulse_sequencer.sv | 161 ++++++++++++++++
 tb/tb_pulse_sequencer.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pulse_sequencer_pkg.sv
// Shared types and width helpers for the pulse-phase sequencer.
package pulse_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } seq_state_t;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n < 2) ? 32'd1 : 32'($clog2(n));
  endfunction

  function automatic int unsigned sel_width(input int unsigned n_reply);
    return clog2_min1(n_reply);
  endfunction

  function automatic int unsigned phase_width(input int unsigned n_phase);
    return clog2_min1(n_phase);
  endfunction

endpackage

// File: rtl/pulse_sequencer_reply_capture.sv
// Registered rising-edge detector for the reply lines; an event shows one cycle after its edge.
module pulse_reply_capture #(
  parameter int unsigned N_REPLY = 3
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic [N_REPLY-1:0] reply_in,
  output logic [N_REPLY-1:0] rep_evt
);

  logic [N_REPLY-1:0] reply_q;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      reply_q <= '0;
      rep_evt <= '0;
    end else begin
      reply_q <= reply_in;
      rep_evt <= reply_in & ~reply_q;
    end
  end

endmodule

// File: rtl/pulse_sequencer.sv
// Pulse-phase sequencer: walks N_PHASE phases, waiting on selected replies, with halt, step and timeout fault.
module pulse_sequencer
  import pulse_seq_pkg::*;
#(
  parameter  int unsigned N_PHASE     = 8,
  parameter  int unsigned N_REPLY     = 3,
  parameter  int unsigned TIMEOUT_CYC = 255,
  localparam int unsigned SEL_W       = sel_width(N_REPLY),
  localparam int unsigned PH_W        = phase_width(N_PHASE)
) (
  input  logic                     clk,
  input  logic                     resetn,
  input  logic                     start_pulse,
  input  logic                     halt_req,
  input  logic                     step_mode,
  input  logic                     step_pulse,
  input  logic                     clear_fault,
  input  logic [N_REPLY-1:0]       reply_in,
  input  logic [N_PHASE-1:0]       wait_mask,
  input  logic [N_PHASE*SEL_W-1:0] reply_sel,
  output logic [PH_W-1:0]          phase,
  output logic [N_PHASE-1:0]       at_phase,
  output logic [N_PHASE-1:0]       leave_phase,
  output logic                     cycle_done,
  output logic                     busy,
  output logic                     fault,
  output logic [PH_W-1:0]          fault_phase
);

  localparam int unsigned T_W    = clog2_min1(TIMEOUT_CYC + 1);
  localparam logic [T_W-1:0] T_LAST = T_W'(TIMEOUT_CYC);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(N_PHASE - 1);

  seq_state_t       state_q, state_d;
  logic [PH_W-1:0]  phase_q, phase_d;
  logic [PH_W-1:0]  fault_phase_q, fault_phase_d;
  logic             hit_q, hit_d;
  logic             step_ok_q, step_ok_d;
  logic             halt_pend_q, halt_pend_d;
  logic [T_W-1:0]   tcnt_q, tcnt_d;

  logic [N_REPLY-1:0] rep_evt;
  logic [SEL_W-1:0]   sel;
  logic               evt_sel;
  logic               is_wait;
  logic               advance;

  pulse_reply_capture #(.N_REPLY(N_REPLY)) u_capture (
    .clk      (clk),
    .resetn   (resetn),
    .reply_in (reply_in),
    .rep_evt  (rep_evt)
  );

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      phase_q       <= '0;
      fault_phase_q <= '0;
      hit_q         <= 1'b0;
      step_ok_q     <= 1'b0;
      halt_pend_q   <= 1'b0;
      tcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      phase_q       <= phase_d;
      fault_phase_q <= fault_phase_d;
      hit_q         <= hit_d;
      step_ok_q     <= step_ok_d;
      halt_pend_q   <= halt_pend_d;
      tcnt_q        <= tcnt_d;
    end
  end

  // Selected reply source; indices beyond N_REPLY never produce an event.
  always_comb begin
    sel     = '0;
    evt_sel = 1'b0;
    for (int unsigned i = 0; i < N_PHASE; i++)
      if (phase_q == PH_W'(i)) sel = reply_sel[i*SEL_W +: SEL_W];
    for (int unsigned k = 0; k < N_REPLY; k++)
      if (sel == SEL_W'(k)) evt_sel = rep_evt[k];
    is_wait = wait_mask[phase_q];
    advance = (state_q == RUN) && (!is_wait || hit_q || evt_sel) &&
              (!step_mode || step_ok_q);
  end

  always_comb begin
    state_d       = state_q;
    phase_d       = phase_q;
    fault_phase_d = fault_phase_q;
    hit_d         = hit_q;
    step_ok_d     = step_ok_q;
    halt_pend_d   = halt_pend_q;
    tcnt_d        = tcnt_q;
    unique case (state_q)
      IDLE: begin
        if (start_pulse) begin
          state_d     = RUN;
          phase_d     = '0;
          hit_d       = 1'b0;
          step_ok_d   = 1'b0;
          halt_pend_d = 1'b0;
          tcnt_d      = '0;
        end
      end
      RUN: begin
        if (halt_req)   halt_pend_d = 1'b1;
        if (step_pulse) step_ok_d   = 1'b1;
        if (advance) begin
          step_ok_d = 1'b0;
          hit_d     = 1'b0;
          tcnt_d    = '0;
          phase_d   = phase_q + 1'b1;
          // A halt request in the final phase still stops at this wrap.
          if (phase_q == PH_LAST && (halt_pend_q || halt_req)) begin
            state_d     = IDLE;
            halt_pend_d = 1'b0;
            phase_d     = '0;
          end
        end else if (is_wait && !hit_q) begin
          if (evt_sel) begin
            hit_d = 1'b1;
          end else if (TIMEOUT_CYC != 0) begin
            if (tcnt_q == T_LAST) begin
              state_d       = FAULT;
              fault_phase_d = phase_q;
            end else begin
              tcnt_d = tcnt_q + 1'b1;
            end
          end
        end
      end
      FAULT: begin
        if (clear_fault) begin
          state_d     = IDLE;
          phase_d     = '0;
          hit_d       = 1'b0;
          step_ok_d   = 1'b0;
          halt_pend_d = 1'b0;
          tcnt_d      = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    at_phase    = '0;
    leave_phase = '0;
    if (state_q == RUN) at_phase[phase_q] = 1'b1;
    if (advance) leave_phase[phase_q] = 1'b1;
  end

  assign phase       = phase_q;
  assign cycle_done  = leave_phase[N_PHASE-1];
  assign busy        = (state_q == RUN);
  assign fault       = (state_q == FAULT);
  assign fault_phase = fault_phase_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Self-checking bench: behavioural sequencer model checked every cycle, plus directed literal checks.
module tb_pulse_sequencer;

  localparam int N_PHASE     = 8;
  localparam int N_REPLY     = 3;
  localparam int TIMEOUT_CYC = 255;
  localparam int SEL_W       = 2;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start_pulse, halt_req, step_mode, step_pulse, clear_fault;
  logic [2:0]  reply_in;
  logic [7:0]  wait_mask;
  logic [15:0] reply_sel;
  logic [2:0]  phase, fault_phase;
  logic [7:0]  at_phase, leave_phase;
  logic        cycle_done, busy, fault;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en = 0;

  pulse_sequencer #(
    .N_PHASE     (N_PHASE),
    .N_REPLY     (N_REPLY),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .start_pulse (start_pulse),
    .halt_req    (halt_req),
    .step_mode   (step_mode),
    .step_pulse  (step_pulse),
    .clear_fault (clear_fault),
    .reply_in    (reply_in),
    .wait_mask   (wait_mask),
    .reply_sel   (reply_sel),
    .phase       (phase),
    .at_phase    (at_phase),
    .leave_phase (leave_phase),
    .cycle_done  (cycle_done),
    .busy        (busy),
    .fault       (fault),
    .fault_phase (fault_phase)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: running/faulted flags, phase number, reply history of the last two samples.
  bit [2:0] h1, h2;
  bit m_run, m_flt, m_got, m_auth, m_halt;
  int m_ph, m_wt, m_fph;

  function automatic int sel_of(input int ph);
    logic [15:0] v;
    v = reply_sel >> (ph * SEL_W);
    return int'(v[1:0]);
  endfunction

  function automatic bit ev_now();
    int s;
    s = sel_of(m_ph);
    return (s < N_REPLY) && h1[s] && !h2[s];
  endfunction

  function automatic bit m_go();
    return m_run && (!wait_mask[m_ph] || m_got || ev_now()) && (!step_mode || m_auth);
  endfunction

  task automatic m_clear();
    m_got = 0; m_auth = 0; m_halt = 0; m_wt = 0;
  endtask

  always @(posedge clk) begin
    bit go, ev, wt;
    if (!resetn) begin
      m_run = 0; m_flt = 0; m_ph = 0; m_fph = 0;
      m_clear();
      h1 = '0; h2 = '0;
      chk_en = 1;
    end else begin
      go = m_go();
      ev = ev_now();
      wt = wait_mask[m_ph];
      if (m_run) begin
        if (halt_req)   m_halt = 1;
        if (step_pulse) m_auth = 1;
        if (go) begin
          m_auth = 0; m_got = 0; m_wt = 0;
          if (m_ph == N_PHASE - 1 && m_halt) begin
            m_run = 0; m_halt = 0; m_ph = 0;
          end else begin
            m_ph = (m_ph + 1) % N_PHASE;
          end
        end else if (wt && !m_got) begin
          if (ev) m_got = 1;
          else begin
            m_wt++;
            if (m_wt > TIMEOUT_CYC) begin
              m_run = 0; m_flt = 1; m_fph = m_ph;
            end
          end
        end
      end else if (m_flt) begin
        if (clear_fault) begin
          m_flt = 0; m_ph = 0;
          m_clear();
        end
      end else if (start_pulse) begin
        m_run = 1; m_ph = 0;
        m_clear();
      end
      h2 = h1;
      h1 = reply_in;
    end
  end

  always @(negedge clk) begin
    bit go;
    if (chk_en) begin
      go = m_go();
      chk("m_phase", 32'(phase), 32'(m_ph));
      chk("m_at_phase", 32'(at_phase), m_run ? (32'd1 << m_ph) : 32'd0);
      chk("m_leave_phase", 32'(leave_phase), go ? (32'd1 << m_ph) : 32'd0);
      chk("m_cycle_done", 32'(cycle_done), 32'(go && m_ph == N_PHASE - 1));
      chk("m_busy", 32'(busy), 32'(m_run));
      chk("m_fault", 32'(fault), 32'(m_flt));
      if (m_flt) chk("m_fault_phase", 32'(fault_phase), 32'(m_fph));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_phase(input int p, input int budget);
    int n;
    n = 0;
    while (int'(phase) != p && n < budget) begin
      tick();
      n++;
    end
    chk("wait_phase", 32'(phase), 32'(p));
  endtask

  task automatic go_idle();
    int n;
    halt_req = 1; tick(); halt_req = 0;
    n = 0;
    while (busy && n < 64) begin
      tick();
      n++;
    end
    chk("go_idle_busy", 32'(busy), 0);
  endtask

  task automatic pulse_reply(input int k);
    reply_in[k] = 1'b1; tick(); reply_in = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    resetn = 0; start_pulse = 0; halt_req = 0; step_mode = 0; step_pulse = 0;
    clear_fault = 0; reply_in = '0; wait_mask = '0; reply_sel = '0;
    tick(); tick();
    resetn = 1;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_phase", 32'(phase), 0);
    chk("rst_at_phase", 32'(at_phase), 0);
    chk("rst_fault", 32'(fault), 0);

    // Auto phases walk 0..7, then continue at 0.
    tick();
    start_pulse = 1; tick(); start_pulse = 0;
    @(negedge clk);
    chk("walk_at0", 32'(at_phase), 32'h01);
    chk("walk_leave0", 32'(leave_phase), 32'h01);
    for (int i = 1; i < 8; i++) begin
      tick();
      @(negedge clk);
      chk("walk_leave", 32'(leave_phase), 32'd1 << i);
    end
    chk("walk_cycle_done", 32'(cycle_done), 1);
    tick();
    @(negedge clk);
    chk("walk_wrap_at0", 32'(at_phase), 32'h01);

    // Halt in phase 3 finishes through 7 then idles.
    wait_phase(3, 16);
    halt_req = 1; tick(); halt_req = 0;
    tick(); tick(); tick();
    @(negedge clk);
    chk("halt_last_busy", 32'(busy), 1);
    chk("halt_last_done", 32'(cycle_done), 1);
    tick();
    @(negedge clk);
    chk("halt_idle_busy", 32'(busy), 0);
    chk("halt_idle_phase", 32'(phase), 0);
    tick();
    start_pulse = 1; tick(); start_pulse = 0;
    @(negedge clk);
    chk("restart_at0", 32'(at_phase), 32'h01);
    go_idle();

    // Wait phases select source 1; source 0 edges are ignored.
    wait_mask = 8'h55; reply_sel = 16'h5555;
    start_pulse = 1; tick(); start_pulse = 0;
    pulse_reply(1);
    wait_phase(2, 20);
    pulse_reply(0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("wrong_src_leave", 32'(leave_phase), 0);
      tick();
    end
    chk("wrong_src_phase", 32'(phase), 2);
    reply_in[1] = 1'b1; tick(); reply_in = '0;
    @(negedge clk);
    chk("reply_leave2", 32'(leave_phase), 32'h04);
    tick();
    chk("reply_phase3", 32'(phase), 3);
    wait_mask = 8'h00;
    go_idle();

    // Step mode: one advance per step, and a latched reply survives until the step.
    step_mode = 1;
    start_pulse = 1; tick(); start_pulse = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("step_hold", 32'(leave_phase), 0);
      tick();
    end
    for (int j = 0; j < 3; j++) begin
      step_pulse = 1; tick(); step_pulse = 0;
      @(negedge clk);
      chk("step_leave", 32'(leave_phase), 32'd1 << j);
      tick();
      @(negedge clk);
      chk("step_after", 32'(leave_phase), 0);
      chk("step_phase", 32'(phase), 32'(j + 1));
    end
    wait_mask = 8'h08;
    pulse_reply(1);
    for (int i = 0; i < 5; i++) begin
      tick();
      @(negedge clk);
      chk("hit_hold", 32'(leave_phase), 0);
    end
    step_pulse = 1; tick(); step_pulse = 0;
    @(negedge clk);
    chk("hit_step_leave", 32'(leave_phase), 32'h08);
    step_mode = 0; wait_mask = 8'h00;
    go_idle();

    // Timeout in phase 4: 256 cycles in the phase, then fault.
    wait_mask = 8'h10;
    start_pulse = 1; tick(); start_pulse = 0;
    wait_phase(4, 20);
    n = 0;
    while (!fault && n < 400) begin
      tick();
      n++;
    end
    chk("timeout_len", 32'(n), 256);
    chk("timeout_fault_phase", 32'(fault_phase), 4);
    clear_fault = 1; tick(); clear_fault = 0;
    @(negedge clk);
    chk("clear_fault", 32'(fault), 0);
    chk("clear_busy", 32'(busy), 0);
    chk("clear_phase", 32'(phase), 0);

    // Reply arriving on the terminal count wins.
    tick();
    start_pulse = 1; tick(); start_pulse = 0;
    wait_phase(4, 20);
    repeat (254) tick();
    reply_in[1] = 1'b1; tick(); reply_in = '0;
    @(negedge clk);
    chk("late_reply_leave", 32'(leave_phase), 32'h10);
    chk("late_reply_nofault", 32'(fault), 0);
    tick();
    chk("late_reply_phase", 32'(phase), 5);
    wait_mask = 8'h00;
    go_idle();

    // Reset in phase 5 with a latched reply.
    step_mode = 1; wait_mask = 8'h20;
    start_pulse = 1; tick(); start_pulse = 0;
    for (int j = 0; j < 5; j++) begin
      step_pulse = 1; tick(); step_pulse = 0; tick();
    end
    chk("rst5_phase", 32'(phase), 5);
    pulse_reply(1);
    tick();
    resetn = 0; tick(); resetn = 1;
    step_mode = 0; wait_mask = 8'h00;
    @(negedge clk);
    chk("rst5_phase0", 32'(phase), 0);
    chk("rst5_at", 32'(at_phase), 0);
    chk("rst5_leave", 32'(leave_phase), 0);
    chk("rst5_busy", 32'(busy), 0);
    chk("rst5_fault_phase", 32'(fault_phase), 0);
    tick();
    start_pulse = 1; tick(); start_pulse = 0;
    @(negedge clk);
    chk("rst5_restart", 32'(at_phase), 32'h01);
    go_idle();

    // Randomized segments checked by the model.
    for (int seg = 0; seg < 12; seg++) begin
      bit quiet;
      wait_mask = 8'($urandom);
      reply_sel = 16'($urandom);
      step_mode = ($urandom_range(0, 3) == 0);
      quiet = ($urandom_range(0, 2) == 0);
      for (int c = 0; c < 400; c++) begin
        start_pulse = ($urandom_range(0, 7) == 0);
        halt_req    = ($urandom_range(0, 63) == 0);
        step_pulse  = ($urandom_range(0, 2) == 0);
        clear_fault = ($urandom_range(0, 15) == 0);
        reply_in    = quiet ? 3'b000 : 3'($urandom);
        resetn      = ($urandom_range(0, 599) != 0);
        tick();
      end
    end
    resetn = 1; start_pulse = 0; halt_req = 0; step_pulse = 0; clear_fault = 0; reply_in = '0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
